// File: rtl/tpu_pkg.sv
// Shared TPU control constants: pass-sequencer FSM encoding and default pass geometry
// used by both the sequencer and the systolic row feeders.
package tpu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } tpu_seq_state_e;

  localparam int unsigned TpuRowsDefault      = 8;
  localparam int unsigned TpuRowCyclesDefault = 4;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned tpu_cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tpu_rise_detect.sv
// Start-request edge detector: samples the request level and emits a one-cycle
// registered launch pulse on each 0->1 transition.
module tpu_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;
  logic rise_q;

  // The launch term is registered so the FSM sees a clean single-cycle pulse,
  // giving two clocks from the sampled request edge to the first row strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      rise_q <= sig_i & ~sig_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/tpu_pass_sequencer.sv
// Expands a start edge into a ROWS x ROW_CYCLES matrix-pass schedule with row strobes.
// Optional abort input enabled by defining TPU_SEQ_ABORT_EN.
module tpu_pass_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS       = TpuRowsDefault,
  parameter int unsigned ROW_CYCLES = TpuRowCyclesDefault,
  parameter int unsigned ROW_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef TPU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             row_load,
  output logic [ROW_W-1:0] row_idx,
  output logic             done
);

  localparam int unsigned CycW = tpu_cnt_width(ROW_CYCLES);
  localparam logic [CycW-1:0]  CycLast = CycW'(ROW_CYCLES - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(ROWS - 1);

  tpu_seq_state_e   state_q;
  logic [CycW-1:0]  cyc_q;
  logic             busy_q;
  logic             row_load_q;
  logic [ROW_W-1:0] row_idx_q;
  logic             done_q;
  logic             launch;
  logic             abort_req;

  tpu_rise_detect u_rise_detect (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (start),
    .rise_o (launch)
  );

`ifdef TPU_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      busy_q     <= 1'b0;
      row_load_q <= 1'b0;
      row_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cyc_q      <= '0;
          row_idx_q  <= '0;
          done_q     <= 1'b0;
          busy_q     <= launch;
          row_load_q <= launch;
          if (launch) state_q <= StRun;
        end
        StRun: begin
          if (abort_req) begin
            state_q    <= StIdle;
            cyc_q      <= '0;
            busy_q     <= 1'b0;
            row_load_q <= 1'b0;
            row_idx_q  <= '0;
          end else if (cyc_q == CycLast) begin
            cyc_q <= '0;
            if (row_idx_q == RowLast) begin
              state_q    <= StDone;
              row_load_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              row_idx_q  <= row_idx_q + 1'b1;
              row_load_q <= 1'b1;
            end
          end else begin
            cyc_q      <= cyc_q + 1'b1;
            row_load_q <= 1'b0;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          row_idx_q <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign row_load = row_load_q;
  assign row_idx  = row_idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tpu_pass_sequencer.sv
// Bench for tpu_pass_sequencer: two instances (8x4 and 3x1) against a pass-timeline model.
module tb_tpu_pass_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort;
  logic       busy_a, load_a, done_a;
  logic [2:0] idx_a;
  logic       busy_b, load_b, done_b;
  logic [1:0] idx_b;

  tpu_pass_sequencer #(.ROWS(8), .ROW_CYCLES(4), .ROW_W(3)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef TPU_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy_a),
    .row_load (load_a),
    .row_idx  (idx_a),
    .done     (done_a)
  );

  tpu_pass_sequencer #(.ROWS(3), .ROW_CYCLES(1), .ROW_W(2)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef TPU_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy_b),
    .row_load (load_b),
    .row_idx  (idx_b),
    .done     (done_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          edge_n   = 0;
  int          rows_m[2] = '{8, 3};
  int          cyc_m[2]  = '{4, 1};
  bit          act[2]    = '{0, 0};
  int          pst[2]    = '{0, 0};
  bit          sprev[2]  = '{0, 0};
  bit          lq[2]     = '{0, 0};
  bit          e_busy[2], e_load[2], e_done[2];
  int          e_idx[2];
  int          dut_done[2] = '{0, 0};
  int          first_load_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
  endtask

  // A pass is a timeline anchored at its launch edge; outputs follow from the offset.
  task automatic model_edge(input int i, input bit st, input bit rst, input bit ab);
    int rc, ph;
    bit run_s, idle_s;
    rc = rows_m[i] * cyc_m[i];
    if (rst) begin
      act[i] = 0; sprev[i] = 0; lq[i] = 0;
    end else begin
      ph = edge_n - 1 - pst[i];
      run_s  = act[i] && ph < rc;
      idle_s = !act[i] || ph > rc;
      if (run_s && ab) act[i] = 0;
      else if (idle_s && lq[i]) begin
        act[i] = 1; pst[i] = edge_n;
      end
      lq[i] = st && !sprev[i];
      sprev[i] = st;
    end
    ph = edge_n - pst[i];
    if (act[i] && ph <= rc) begin
      e_busy[i] = 1;
      e_load[i] = (ph < rc) && (ph % cyc_m[i] == 0);
      e_idx[i]  = (ph < rc) ? ph / cyc_m[i] : rows_m[i] - 1;
      e_done[i] = (ph == rc);
    end else begin
      e_busy[i] = 0; e_load[i] = 0; e_idx[i] = 0; e_done[i] = 0;
    end
  endtask

  task automatic step(input bit st, input bit rst, input bit ab);
    start = st; reset = rst; abort = ab;
    @(posedge clk);
    edge_n++;
    model_edge(0, st, rst, ab);
    model_edge(1, st, rst, ab);
    #1;
    if (done_a === 1'b1) dut_done[0]++;
    if (done_b === 1'b1) dut_done[1]++;
    chk("busy_a", 32'(busy_a), 32'(e_busy[0]));
    chk("load_a", 32'(load_a), 32'(e_load[0]));
    chk("idx_a",  32'(idx_a),  32'(e_idx[0]));
    chk("done_a", 32'(done_a), 32'(e_done[0]));
    chk("busy_b", 32'(busy_b), 32'(e_busy[1]));
    chk("load_b", 32'(load_b), 32'(e_load[1]));
    chk("idx_b",  32'(idx_b),  32'(e_idx[1]));
    chk("done_b", 32'(done_b), 32'(e_done[1]));
  endtask

  initial begin
    int snap_a, snap_b, start_edge, k;
    bit st, ab_en;
`ifdef TPU_SEQ_ABORT_EN
    ab_en = 1;
`else
    ab_en = 0;
`endif
    start = 0; reset = 1; abort = 0;
    repeat (3) step(0, 1, 0);
    repeat (6) step(0, 0, 0);

    // Basic pass, start held high for 100 cycles: single pass, measured latency
    snap_a = dut_done[0]; snap_b = dut_done[1];
    start_edge = edge_n;
    first_load_edge = -1;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0);
      if (first_load_edge < 0 && load_a === 1'b1) first_load_edge = edge_n;
    end
    chk("latency_a", 32'(first_load_edge - start_edge), 32'd2);
    chk("held_done_a", 32'(dut_done[0] - snap_a), 32'd1);
    chk("held_done_b", 32'(dut_done[1] - snap_b), 32'd1);
    repeat (3) step(0, 0, 0);
    snap_a = dut_done[0];
    repeat (40) step(1, 0, 0);
    chk("second_pass_a", 32'(dut_done[0] - snap_a), 32'd1);
    repeat (3) step(0, 0, 0);

    // Reset mid-pass at row 3, then a clean full pass
    step(1, 0, 0);
    for (k = 0; k < 40 && e_idx[0] != 3; k++) step(1, 0, 0);
    chk("reached_row3", 32'(idx_a), 32'd3);
    snap_a = dut_done[0];
    step(1, 1, 0);
    chk("rst_no_done", 32'(dut_done[0] - snap_a), 32'd0);
    step(0, 0, 0);
    repeat (40) step(1, 0, 0);
    chk("post_rst_pass", 32'(dut_done[0] - snap_a), 32'd1);
    repeat (3) step(0, 0, 0);

    // Start edge during row 5 is ignored
    snap_a = dut_done[0];
    step(1, 0, 0);
    for (k = 0; k < 40 && e_idx[0] != 5; k++) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (40) step(1, 0, 0);
    chk("run_edge_ignored", 32'(dut_done[0] - snap_a), 32'd1);
    repeat (3) step(0, 0, 0);

    if (ab_en) begin
      snap_a = dut_done[0];
      step(1, 0, 0);
      for (k = 0; k < 40 && e_idx[0] != 2; k++) step(1, 0, 0);
      step(1, 0, 1);
      chk("abort_busy", 32'(busy_a), 32'd0);
      repeat (10) step(0, 0, 0);
      repeat (5) step(0, 0, 1);
      chk("abort_no_done", 32'(dut_done[0] - snap_a), 32'd0);
    end

    // Randomized traffic
    st = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) st = !st;
      step(st, $urandom_range(299) == 0, ab_en && $urandom_range(39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tpu_pass_sequencer.md
Name: tpu_pass_sequencer

Overview:
- Inverse of the registered start-edge gating used by the TPU control path. It takes a start pulse or level from the host or controller and expands it into a multi-cycle matrix-pass schedule.
- Outputs: busy level, per-row load strobes with row index, and a one-cycle done pulse.
- Sits between the TPU controller and the systolic row feeders. It paces ROWS rows, each lasting ROW_CYCLES clocks.

Parameters:
- ROWS, 8, number of rows per pass (>=1)
- ROW_CYCLES, 4, clocks per row (>=1)
- ROW_W, 3, width of the row index; must satisfy 2**ROW_W >= ROWS

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request level; a pass launches on its rising edge (start & !start_q)
- busy  output  1  high from the first RUN cycle through the DONE cycle
- row_load  output  1  one-cycle strobe on the first clock of each row
- row_idx  output  ROW_W  index of the current row, 0..ROWS-1
- done  output  1  one-cycle pulse after the last row completes
- abort  input  1  present only with TPU_SEQ_ABORT_EN (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset values: busy=0, row_load=0, row_idx=0, done=0, start_q=0, state=IDLE, cycle counter=0.
- Start detection:
  - start_q <= start every cycle.
  - launch = start & !start_q, evaluated in IDLE only.
  - A start held high does not relaunch. A new rising edge is required after done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On launch: go to RUN; next cycle busy=1, row_load=1, row_idx=0, cyc=0.
  - Latency from the start rising edge to row_load is 2 clocks: 1 for start_q, 1 for the registered output.
- RUN:
  - cyc increments each clock.
  - When cyc==ROW_CYCLES-1 and row_idx<ROWS-1: cyc<=0, row_idx<=row_idx+1, row_load<=1.
  - Otherwise row_load<=0.
  - When cyc==ROW_CYCLES-1 and row_idx==ROWS-1: go to DONE with done<=1.
- DONE:
  - Lasts exactly one cycle with busy=1, done=1.
  - Next cycle: IDLE, busy=0, done=0, row_idx=0.
- Total busy duration is ROWS*ROW_CYCLES+1 clocks.
- ROW_CYCLES=1: row_load stays high on every RUN cycle and row_idx advances each clock.
- ROWS=1: a single row_load, then done after ROW_CYCLES clocks.
- Edges of start during RUN or DONE are ignored and not queued. start_q still tracks start, so an edge occurring while busy is lost.
- Reset asserted mid-pass: all outputs go to their reset values on the next edge. No done pulse is emitted.
- Reset takes priority over everything.
- Counter width is $clog2(ROW_CYCLES) bits, minimum 1. No wrap occurs beyond ROW_CYCLES-1.

Optional Feature:
- Macro: TPU_SEQ_ABORT_EN.
- Defined:
  - Adds the abort input. abort=1 in RUN goes to IDLE on the next edge: busy=0, row_load=0, row_idx=0, done stays 0.
  - abort in IDLE or DONE has no effect.
  - abort and reset together: reset wins (same result).
- Undefined: no abort port, and RUN always runs to completion.

Decomposition:
- Shared package tpu_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default ROWS/ROW_CYCLES constants shared with the row feeders
- One natural sub-module: tpu_rise_detect, which is the start_q register plus the start & !start_q launch term.
- The cycle counter and FSM stay inline.

Test Plan:
- Reset then ROWS=8, ROW_CYCLES=4, start 0->1 at cycle 10:
  - row_load at cycles 12,16,...,40 with row_idx 0..7
  - done at cycle 44; busy high cycles 12..44
- start held high for 100 cycles: exactly one pass and one done pulse. A second 0->1 edge after done launches a second pass.
- ROW_CYCLES=1, ROWS=3: row_load high 3 consecutive cycles with row_idx 0,1,2, then done on the next cycle.
- reset pulsed at row_idx=3: the next cycle has busy=0, row_idx=0, and no done. A new start edge runs a full pass normally.
- Start edge during RUN (row 5): ignored, so only one done is emitted and no second pass follows.
- With TPU_SEQ_ABORT_EN, abort at row 2:
  - next cycle busy=0, done never asserted
  - abort during IDLE leaves outputs unchanged
